sram_like_arbiter: RTL and testbench

- Two-master to one-slave arbiter for the CPU's sram-like memory interface.
- Shares the single memory port between the instruction-fetch requester (inst_*) and the load/store requester (data_*; loads complete in the MEM stage).
- Allows one outstanding transaction at a time, with data-over-inst priority plus an anti-starvation counter.
- Suppresses inst responses that belong to a flushed fetch.

---
 rtl/sram_like_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the sram-like memory port.
// One outstanding transaction, data-over-inst priority with anti-starvation, flushed-fetch response suppression.
module sram_like_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ADDR = 2'd1;
    localparam logic [1:0] ST_WAIT_DATA = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [2:0] starve_cnt_q, starve_cnt_d;
    logic       inst_discard_q, inst_discard_d;

    logic [1:0] grant_s;
    logic       s_req_s;
    logic       addr_hs_s;
    logic       rsp_s;

    // Master currently driving the slave command bus (locked to owner once issued)
    always_comb begin
        grant_s = OWN_NONE;
        case (state_q)
            ST_IDLE: begin
                if (!resetn) begin
                    grant_s = OWN_NONE;
                end else if (inst_req && (!data_req || (starve_cnt_q == LIMIT))) begin
                    grant_s = OWN_INST;
                end else if (data_req) begin
                    grant_s = OWN_DATA;
                end else begin
                    grant_s = OWN_NONE;
                end
            end
            ST_WAIT_ADDR: grant_s = owner_q;
            default:      grant_s = OWN_NONE;
        endcase
    end

    // Request qualification and handshake detection
    always_comb begin
        s_req_s = 1'b0;
        case (grant_s)
            OWN_INST: s_req_s = inst_req;
            OWN_DATA: s_req_s = data_req;
            default:  s_req_s = 1'b0;
        endcase
        addr_hs_s = s_req_s && s_addr_ok;
        rsp_s     = (state_q == ST_WAIT_DATA) && s_data_ok;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN_NONE;
            starve_cnt_q   <= 3'd0;
            inst_discard_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            starve_cnt_q   <= starve_cnt_d;
            inst_discard_q <= inst_discard_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        inst_discard_d = inst_discard_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s != OWN_NONE) begin
                    owner_d = grant_s;
                    state_d = addr_hs_s ? ST_WAIT_DATA : ST_WAIT_ADDR;
                end else begin
                    owner_d = OWN_NONE;
                end
            end
            ST_WAIT_ADDR: begin
                if (addr_hs_s) begin
                    state_d = ST_WAIT_DATA;
                end else begin
                    state_d = ST_WAIT_ADDR;
                end
            end
            ST_WAIT_DATA: begin
                if (s_data_ok) begin
                    state_d        = ST_IDLE;
                    owner_d        = OWN_NONE;
                    inst_discard_d = 1'b0;
                end else if (flush && (owner_q == OWN_INST)) begin
                    inst_discard_d = 1'b1;
                end else begin
                    inst_discard_d = inst_discard_q;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                owner_d        = OWN_NONE;
                inst_discard_d = 1'b0;
            end
        endcase

        // A fetch flushed in its own acceptance cycle is already stale
        if (addr_hs_s && (grant_s == OWN_INST) && flush) begin
            inst_discard_d = 1'b1;
        end else begin
            inst_discard_d = inst_discard_d;
        end

        if (!addr_hs_s) begin
            starve_cnt_d = starve_cnt_q;
        end else if (grant_s == OWN_INST) begin
            starve_cnt_d = 3'd0;
        end else if (inst_req) begin
            starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : (starve_cnt_q + 3'd1);
        end else begin
            starve_cnt_d = 3'd0;
        end
    end

    // Output logic: command mux and per-master handshakes
    always_comb begin
        s_req   = s_req_s;
        s_wr    = 1'b0;
        s_size  = 2'd0;
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        case (grant_s)
            OWN_INST: begin
                s_wr    = inst_wr;
                s_size  = inst_size;
                s_addr  = inst_addr;
                s_wdata = inst_wdata;
            end
            OWN_DATA: begin
                s_wr    = data_wr;
                s_size  = data_size;
                s_addr  = data_addr;
                s_wdata = data_wdata;
            end
            default: begin
                s_wr    = 1'b0;
                s_size  = 2'd0;
                s_addr  = 32'd0;
                s_wdata = 32'd0;
            end
        endcase

        inst_addr_ok = addr_hs_s && (grant_s == OWN_INST);
        data_addr_ok = addr_hs_s && (grant_s == OWN_DATA);
        inst_data_ok = rsp_s && (owner_q == OWN_INST) && !inst_discard_q && !flush;
        data_data_ok = rsp_s && (owner_q == OWN_DATA);
        inst_rdata   = inst_data_ok ? s_rdata : 32'd0;
        data_rdata   = data_data_ok ? s_rdata : 32'd0;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_sram_like_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd0;
    logic [31:0] inst_addr = 32'd0, inst_wdata = 32'd0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok = 1'b0, s_data_ok = 1'b0;
    logic [31:0] s_rdata = 32'd0;

    int checks = 0;
    int failures = 0;

    sram_like_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        flush = 1'b0; inst_req = 1'b0; data_req = 1'b0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'd0;
        inst_wr = 1'b0; inst_size = 2'd2; data_wr = 1'b0; data_size = 2'd2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
        inst_addr = 32'h0000_0044; data_addr = 32'h0000_0088;
        #1;
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL reset_s_req got=%b exp=0", s_req); end
        checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
            failures++; $display("FAIL reset_oks got=%b exp=0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        checks++; if ({s_wr, s_size, s_addr, s_wdata, inst_rdata, data_rdata} !== 131'd0) begin
            failures++; $display("FAIL reset_cmd got addr=%h size=%0d rd=%h/%h exp=0", s_addr, s_size, inst_rdata, data_rdata); end
        @(negedge clk);
        idle_inputs();
        resetn = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h0000_1000; s_addr_ok = 1'b1;
        #1;
        checks++; if (!(s_req === 1'b1 && s_addr === 32'h0000_1000 && data_addr_ok === 1'b1 && inst_addr_ok === 1'b0)) begin
            failures++; $display("FAIL single_issue got req=%b addr=%h aok=%b exp req=1 addr=00001000 aok=1", s_req, s_addr, data_addr_ok); end
        @(negedge clk);
        data_req = 1'b0; s_addr_ok = 1'b0;
        #1;
        checks++; if (s_req !== 1'b0 || data_data_ok !== 1'b0) begin
            failures++; $display("FAIL single_wait got req=%b dok=%b exp=0,0", s_req, data_data_ok); end
        @(negedge clk);
        s_data_ok = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (!(data_data_ok === 1'b1 && data_rdata === 32'hDEAD_BEEF && inst_data_ok === 1'b0 && inst_rdata === 32'd0)) begin
            failures++; $display("FAIL single_resp got dok=%b rdata=%h idok=%b exp dok=1 rdata=deadbeef idok=0", data_data_ok, data_rdata, inst_data_ok); end
        @(negedge clk);
        s_data_ok = 1'b0;
        #1;
        checks++; if (data_data_ok !== 1'b0 || s_req !== 1'b0) begin
            failures++; $display("FAIL single_done got dok=%b req=%b exp=0,0", data_data_ok, s_req); end
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h0000_2000; data_req = 1'b1; data_addr = 32'h0000_3000; s_addr_ok = 1'b1;
        #1;
        checks++; if (s_addr !== 32'h0000_3000 || data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            failures++; $display("FAIL contention_first got addr=%h daok=%b iaok=%b exp 00003000,1,0", s_addr, data_addr_ok, inst_addr_ok); end
        @(negedge clk);
        data_req = 1'b0;
        @(negedge clk);
        s_data_ok = 1'b1; s_rdata = 32'h0000_0001;
        #1;
        checks++; if (s_req !== 1'b0 || inst_addr_ok !== 1'b0 || data_data_ok !== 1'b1) begin
            failures++; $display("FAIL contention_bubble got req=%b iaok=%b ddok=%b exp 0,0,1", s_req, inst_addr_ok, data_data_ok); end
        @(negedge clk);
        s_data_ok = 1'b0;
        #1;
        checks++; if (s_addr !== 32'h0000_2000 || inst_addr_ok !== 1'b1) begin
            failures++; $display("FAIL contention_second got addr=%h iaok=%b exp 00002000,1", s_addr, inst_addr_ok); end
        @(negedge clk);
        inst_req = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h0000_0002;
        #1;
        checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0000_0002) begin
            failures++; $display("FAIL contention_inst_resp got dok=%b rdata=%h exp 1,00000002", inst_data_ok, inst_rdata); end
        @(negedge clk);
        s_data_ok = 1'b0;
    endtask

    task automatic test_starvation();
        string got;
        string exp;
        logic prev_hs;
        got = ""; exp = ""; prev_hs = 1'b0;
        for (int i = 0; i < LIMIT; i++) exp = {exp, "D"};
        exp = {exp, "ID"};
        do_reset();
        for (int c = 0; c < 2 * (LIMIT + 2); c++) begin
            @(negedge clk);
            inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h0000_4000; data_addr = 32'h0000_5000;
            s_addr_ok = 1'b1; s_data_ok = prev_hs;
            #1;
            if (inst_addr_ok) got = {got, "I"};
            if (data_addr_ok) got = {got, "D"};
            prev_hs = inst_addr_ok | data_addr_ok;
        end
        checks++; if (got != exp) begin failures++; $display("FAIL starvation_order got=%s exp=%s", got, exp); end
        idle_inputs();
    endtask

    task automatic test_locked_grant();
        do_reset();
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h0000_6000; data_addr = 32'h0000_7000;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) data_req = 1'b1;
            s_addr_ok = (c == 3);
            #1;
            checks++; if (s_addr !== 32'h0000_6000 || s_req !== 1'b1 || data_addr_ok !== 1'b0 || inst_addr_ok !== (c == 3)) begin
                failures++; $display("FAIL locked_c%0d got addr=%h req=%b daok=%b iaok=%b exp 00006000,1,0,%0d",
                                     c, s_addr, s_req, data_addr_ok, inst_addr_ok, (c == 3)); end
            @(negedge clk);
        end
        inst_req = 1'b0;
        s_data_ok = 1'b1; s_rdata = 32'h0000_0600;
        #1;
        checks++; if (inst_data_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            failures++; $display("FAIL locked_resp got idok=%b daok=%b exp 1,0", inst_data_ok, data_addr_ok); end
        @(negedge clk);
        s_data_ok = 1'b0;
        #1;
        checks++; if (data_addr_ok !== 1'b1 || s_addr !== 32'h0000_7000) begin
            failures++; $display("FAIL locked_data_next got daok=%b addr=%h exp 1,00007000", data_addr_ok, s_addr); end
        @(negedge clk);
        idle_inputs(); s_data_ok = 1'b1;
        @(negedge clk);
        s_data_ok = 1'b0;
    endtask

    task automatic test_flush_discard();
        do_reset();
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h0000_8000; s_addr_ok = 1'b1;
        @(negedge clk);
        inst_req = 1'b0; s_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        checks++; if (inst_data_ok !== 1'b0) begin failures++; $display("FAIL flush_suppress got idok=%b exp 0", inst_data_ok); end
        @(negedge clk);
        s_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h0000_8004; s_addr_ok = 1'b1;
        #1;
        checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL flush_next_issue got iaok=%b exp 1", inst_addr_ok); end
        @(negedge clk);
        inst_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL flush_next_resp got idok=%b rdata=%h exp 1,cafef00d", inst_data_ok, inst_rdata); end
        @(negedge clk);
        s_data_ok = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h0000_9000; s_addr_ok = 1'b1;
        @(negedge clk);
        data_req = 1'b0; s_addr_ok = 1'b0; inst_req = 1'b1; s_data_ok = 1'b1;
        #2 resetn = 1'b0;
        #1;
        checks++; if ({s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b00000) begin
            failures++; $display("FAIL async_reset_drop got=%b exp=00000", {s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        @(negedge clk);
        resetn = 1'b1; inst_req = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h5555_AAAA;
        #1;
        checks++; if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
            failures++; $display("FAIL async_reset_late_resp got ddok=%b idok=%b exp 0,0", data_data_ok, inst_data_ok); end
        @(negedge clk);
        s_data_ok = 1'b0;
    endtask

    task automatic test_random();
        // Transaction-level model: one slot that is either empty, issued, or accepted
        bit m_has, m_acc, m_inst, m_disc, has0;
        int m_streak, pick;
        bit i_pend, d_pend, e_sreq, hs, rsp, e_iaok, e_daok, e_idok, e_ddok;
        logic [31:0] e_addr, e_wdata, e_ird, e_drd;
        logic [1:0] e_size;
        logic e_wr;
        m_has = 0; m_acc = 0; m_inst = 0; m_disc = 0; m_streak = 0;
        i_pend = 0; d_pend = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!i_pend && ($urandom_range(0, 2) == 0)) begin
                i_pend = 1; inst_addr = $urandom; inst_wdata = $urandom;
                inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'($urandom_range(0, 2));
            end
            if (!d_pend && ($urandom_range(0, 1) == 0)) begin
                d_pend = 1; data_addr = $urandom; data_wdata = $urandom;
                data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
            end
            inst_req = i_pend; data_req = d_pend;
            flush = ($urandom_range(0, 5) == 0);
            s_addr_ok = 1'($urandom_range(0, 1));
            s_data_ok = ($urandom_range(0, 2) == 0);
            s_rdata = $urandom;

            if (!m_has) begin
                pick = (inst_req && (!data_req || m_streak == LIMIT)) ? 1 : (data_req ? 2 : 0);
                e_sreq = (pick != 0);
            end else if (!m_acc) begin
                pick = m_inst ? 1 : 2;
                e_sreq = m_inst ? inst_req : data_req;
            end else begin
                pick = 0; e_sreq = 0;
            end
            e_addr = (pick == 1) ? inst_addr : (pick == 2) ? data_addr : 32'd0;
            e_wdata = (pick == 1) ? inst_wdata : (pick == 2) ? data_wdata : 32'd0;
            e_size = (pick == 1) ? inst_size : (pick == 2) ? data_size : 2'd0;
            e_wr = (pick == 1) ? inst_wr : (pick == 2) ? data_wr : 1'b0;
            hs = e_sreq && s_addr_ok;
            rsp = m_has && m_acc && s_data_ok;
            e_iaok = hs && (pick == 1);
            e_daok = hs && (pick == 2);
            e_idok = rsp && m_inst && !m_disc && !flush;
            e_ddok = rsp && !m_inst;
            e_ird = e_idok ? s_rdata : 32'd0;
            e_drd = e_ddok ? s_rdata : 32'd0;
            #1;
            checks++; if ({s_req, s_wr, s_size, s_addr, s_wdata} !== {e_sreq, e_wr, e_size, e_addr, e_wdata}) begin
                failures++; $display("FAIL rand_cmd c=%0d got req=%b addr=%h exp req=%b addr=%h", c, s_req, s_addr, e_sreq, e_addr); end
            checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== {e_iaok, e_daok, e_idok, e_ddok}) begin
                failures++; $display("FAIL rand_oks c=%0d got=%b exp=%b", c,
                    {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, {e_iaok, e_daok, e_idok, e_ddok}); end
            checks++; if (inst_rdata !== e_ird || data_rdata !== e_drd) begin
                failures++; $display("FAIL rand_rdata c=%0d got=%h/%h exp=%h/%h", c, inst_rdata, data_rdata, e_ird, e_drd); end

            has0 = m_has;
            if (rsp) begin
                m_has = 0; m_disc = 0;
            end else if (m_has && m_acc && m_inst && flush) begin
                m_disc = 1;
            end
            if (hs) begin
                if (pick == 1) m_streak = 0;
                else if (inst_req) m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
                else m_streak = 0;
                m_has = 1; m_acc = 1; m_inst = (pick == 1); m_disc = (pick == 1) && flush;
                if (pick == 1) i_pend = 0; else d_pend = 0;
            end else if (!has0 && pick != 0) begin
                m_has = 1; m_acc = 0; m_inst = (pick == 1); m_disc = 0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_starvation();
        test_locked_grant();
        test_flush_discard();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
